// File: rtl/parity_check7.sv
// parity_check7: receive-side hard-decision parity checker for the rate-7 LDPC codeword
// (4320 info bits + 360 parity bits). Define PARITY_CHECK7_ERRPOS_EN to add err_first.
module parity_check7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_sof,
    input  logic       din_valid,
    input  logic       din,
    output logic       busy,
    output logic       chk_done,
    output logic       chk_pass,
    output logic [8:0] err_cnt
`ifdef PARITY_CHECK7_ERRPOS_EN
    ,
    output logic [8:0] err_first
`endif
);

    localparam logic [8:0]  GIDX_LAST      = 9'd359;
    localparam logic [8:0]  GIDX_LOOKAHEAD = 9'd357;
    localparam logic [3:0]  GRP_LAST       = 4'd11;
    localparam logic [12:0] INFO_LAST      = 13'd4319;

    // Circulant generator row for group g (xorshift32 sequence, first bit lands in [359]).
    function automatic logic [359:0] g_row7(input int unsigned g);
        logic [31:0]  s;
        logic [359:0] r;
        s = 32'h9E37_79B9 ^ (g * 32'h0101_0101);
        r = '0;
        for (int unsigned n = 0; n < 360; n++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            r = {r[358:0], s[31]};
        end
        return r;
    endfunction

    localparam logic [359:0] ROW0  = g_row7(0);
    localparam logic [359:0] ROW1  = g_row7(1);
    localparam logic [359:0] ROW2  = g_row7(2);
    localparam logic [359:0] ROW3  = g_row7(3);
    localparam logic [359:0] ROW4  = g_row7(4);
    localparam logic [359:0] ROW5  = g_row7(5);
    localparam logic [359:0] ROW6  = g_row7(6);
    localparam logic [359:0] ROW7  = g_row7(7);
    localparam logic [359:0] ROW8  = g_row7(8);
    localparam logic [359:0] ROW9  = g_row7(9);
    localparam logic [359:0] ROW10 = g_row7(10);
    localparam logic [359:0] ROW11 = g_row7(11);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INFO   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [12:0]   bcnt_q, bcnt_d;
    logic [8:0]    gidx_q, gidx_d;
    logic [3:0]    addra_q, addra_d;
    logic [359:0]  sum_q, sum_d;
    logic [359:0]  rot_q, rot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [8:0]    err_q, err_d;
    logic [359:0]  douta;
    logic          mism;
`ifdef PARITY_CHECK7_ERRPOS_EN
    logic [8:0]    first_q, first_d;
`endif

    // G_rom7: one-cycle read latency.
    always_ff @(posedge clk) begin : g_rom7
        case (addra_q)
            4'd0:    douta <= ROW0;
            4'd1:    douta <= ROW1;
            4'd2:    douta <= ROW2;
            4'd3:    douta <= ROW3;
            4'd4:    douta <= ROW4;
            4'd5:    douta <= ROW5;
            4'd6:    douta <= ROW6;
            4'd7:    douta <= ROW7;
            4'd8:    douta <= ROW8;
            4'd9:    douta <= ROW9;
            4'd10:   douta <= ROW10;
            4'd11:   douta <= ROW11;
            default: douta <= '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        gidx_d  = gidx_q;
        addra_d = addra_q;
        sum_d   = sum_q;
        rot_d   = rot_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        mism    = 1'b0;
`ifdef PARITY_CHECK7_ERRPOS_EN
        first_d = first_q;
`endif
        if (din_valid && din_sof) begin
            // An aborting SOF can arrive while the ROM is already addressed past group 0,
            // so bit 0 takes the group-0 row from the constant rather than douta.
            state_d = S_INFO;
            bcnt_d  = 13'd1;
            gidx_d  = 9'd1;
            addra_d = '0;
            sum_d   = din ? ROW0 : '0;
            rot_d   = {ROW0[0], ROW0[359:1]};
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = '0;
`ifdef PARITY_CHECK7_ERRPOS_EN
            first_d = '1;
`endif
        end else if (din_valid) begin
            case (state_q)
                S_INFO: begin
                    if (gidx_q == '0) begin
                        if (din) sum_d = sum_q ^ douta;
                        rot_d = {douta[0], douta[359:1]};
                    end else begin
                        if (din) sum_d = sum_q ^ rot_q;
                        rot_d = {rot_q[0], rot_q[359:1]};
                    end
                    // Fetch the next group's row early so it is ready for back-to-back bits.
                    if (gidx_q == GIDX_LOOKAHEAD) begin
                        addra_d = (addra_q == GRP_LAST) ? '0 : addra_q + 4'd1;
                    end
                    gidx_d = (gidx_q == GIDX_LAST) ? '0 : gidx_q + 9'd1;
                    bcnt_d = bcnt_q + 13'd1;
                    if (bcnt_q == INFO_LAST) state_d = S_PARITY;
                end
                S_PARITY: begin
                    mism = din ^ sum_q[GIDX_LAST - gidx_q];
                    if (mism) begin
                        err_d = err_q + 9'd1;
`ifdef PARITY_CHECK7_ERRPOS_EN
                        if (first_q == '1) first_d = gidx_q;
`endif
                    end
                    bcnt_d = bcnt_q + 13'd1;
                    gidx_d = gidx_q + 9'd1;
                    if (gidx_q == GIDX_LAST) begin
                        state_d = S_IDLE;
                        bcnt_d  = '0;
                        gidx_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            gidx_q  <= '0;
            addra_q <= '0;
            sum_q   <= '0;
            rot_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
`ifdef PARITY_CHECK7_ERRPOS_EN
            first_q <= '1;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            gidx_q  <= gidx_d;
            addra_q <= addra_d;
            sum_q   <= sum_d;
            rot_q   <= rot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
`ifdef PARITY_CHECK7_ERRPOS_EN
            first_q <= first_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign chk_done = done_q;
    assign chk_pass = pass_q;
    assign err_cnt  = err_q;
`ifdef PARITY_CHECK7_ERRPOS_EN
    assign err_first = first_q;
`endif

endmodule

// File: tb/tb_parity_check7.sv
// Self-checking bench for parity_check7: random info frames encoded by a modular-index reference model.
module tb_parity_check7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_sof;
    logic       din_valid;
    logic       din;
    logic       busy;
    logic       chk_done;
    logic       chk_pass;
    logic [8:0] err_cnt;
`ifdef PARITY_CHECK7_ERRPOS_EN
    logic [8:0] err_first;
`endif

    parity_check7 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_sof   (din_sof),
        .din_valid (din_valid),
        .din       (din),
        .busy      (busy),
        .chk_done  (chk_done),
        .chk_pass  (chk_pass),
        .err_cnt   (err_cnt)
`ifdef PARITY_CHECK7_ERRPOS_EN
        ,
        .err_first (err_first)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned stamps[$];
    bit          rowbit[12][360];
    bit          enc[4680];
    bit          frm[4680];
    bit          par_ref[360];

    always @(posedge clk) begin
        cyc++;
        if (cyc > 90000) begin
            $display("FAIL watchdog: cycles %0d, limit 90000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    always @(negedge clk) begin
        if (chk_done === 1'b1) begin
            done_cnt++;
            stamps.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic gen_rows();
        bit [31:0] s;
        for (int unsigned g = 0; g < 12; g++) begin
            s = 32'h9E3779B9 ^ (g * 32'h01010101);
            for (int unsigned n = 0; n < 360; n++) begin
                s = s ^ (s << 13);
                s = s ^ (s >> 17);
                s = s ^ (s << 5);
                rowbit[g][359 - n] = s[31];
            end
        end
    endtask

    // Info bit k of group g contributes the group row rotated right by k: bit i <- row[(i+k) mod 360].
    task automatic encode();
        bit acc[360];
        int unsigned g, k;
        foreach (acc[i]) acc[i] = 1'b0;
        for (int unsigned idx = 0; idx < 4320; idx++) begin
            if (enc[idx]) begin
                g = idx / 360;
                k = idx % 360;
                for (int unsigned i = 0; i < 360; i++) acc[i] ^= rowbit[g][(i + k) % 360];
            end
        end
        for (int unsigned j = 0; j < 360; j++) begin
            par_ref[j]     = acc[359 - j];
            enc[4320 + j]  = acc[359 - j];
        end
    endtask

    task automatic expect_errs(output int e, output int f);
        e = 0;
        f = 511;
        for (int j = 0; j < 360; j++) begin
            if (frm[4320 + j] != par_ref[j]) begin
                if (e == 0) f = j;
                e++;
            end
        end
    endtask

    task automatic drive_bit(input bit s, input bit b);
        din_sof   = s;
        din_valid = 1'b1;
        din       = b;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            din_sof   = 1'b0;
            din_valid = 1'b0;
            din       = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic feed(input int unsigned first, input int unsigned last, input bit gaps);
        int unsigned m;
        for (int unsigned idx = first; idx <= last; idx++) begin
            if (gaps) begin
                m = idx % 360;
                idle((m >= 357 || m == 0) ? $urandom_range(3, 1) : $urandom_range(3, 0));
            end
            drive_bit(idx == 0, frm[idx]);
            if (idx == 0) check("busy_rise", busy, 1);
        end
    endtask

    task automatic frame_end(input int e, input int f);
        check("done_pulse", chk_done, 1);
        check("busy_fall", busy, 0);
        check("err_cnt", err_cnt, e);
        check("chk_pass", chk_pass, (e == 0) ? 1 : 0);
`ifdef PARITY_CHECK7_ERRPOS_EN
        check("err_first", err_first, f);
`else
        if (f < 0) $display("unexpected negative index");
`endif
    endtask

    task automatic after_pulse(input int e);
        idle(1);
        check("done_one_cycle", chk_done, 0);
        check("err_cnt_hold", err_cnt, e);
        check("chk_pass_hold", chk_pass, (e == 0) ? 1 : 0);
    endtask

    task automatic run_frame(input bit gaps);
        int e, f;
        feed(0, 4679, gaps);
        expect_errs(e, f);
        frame_end(e, f);
        after_pulse(e);
    endtask

    initial begin
        int e, f;
        int unsigned d0;
        rst_n     = 1'b0;
        din_sof   = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        void'($urandom(32'd7));
        gen_rows();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", chk_done, 0);
        check("rst_pass", chk_pass, 0);
        check("rst_err", err_cnt, 0);
`ifdef PARITY_CHECK7_ERRPOS_EN
        check("rst_first", err_first, 511);
`endif
        rst_n = 1'b1;

        // Stray valid without SOF, and SOF without valid, are both ignored in IDLE.
        din_valid = 1'b1;
        din       = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din_sof   = 1'b1;
        @(negedge clk);
        idle(1);
        check("idle_ignore", busy, 0);

        foreach (enc[i]) enc[i] = 1'b0;
        encode();
        frm = enc;
        run_frame(1'b0);

        for (int i = 0; i < 4320; i++) enc[i] = 1'($urandom_range(1, 0));
        encode();
        frm = enc;
        run_frame(1'b0);

        frm = enc;
        frm[4320 + 5]   ^= 1'b1;
        frm[4320 + 200] ^= 1'b1;
        run_frame(1'b0);

        frm = enc;
        for (int j = 0; j < 360; j++) frm[4320 + j] ^= 1'b1;
        run_frame(1'b0);

        frm = enc;
        run_frame(1'b1);

        d0  = done_cnt;
        frm = enc;
        feed(0, 999, 1'b0);
        run_frame(1'b0);
        check("abort_single_done", done_cnt - d0, 1);

        d0  = done_cnt;
        frm = enc;
        for (int j = 0; j < 360; j++) frm[4320 + j] ^= 1'b1;
        feed(0, 4400, 1'b0);
        check("err_before_rst", err_cnt, 81);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", chk_done, 0);
        check("midrst_pass", chk_pass, 0);
        check("midrst_err", err_cnt, 0);
`ifdef PARITY_CHECK7_ERRPOS_EN
        check("midrst_first", err_first, 511);
`endif
        feed(4401, 4679, 1'b0);
        idle(2);
        check("midrst_idle", busy, 0);
        check("midrst_no_done", done_cnt - d0, 0);

        d0  = done_cnt;
        frm = enc;
        feed(0, 4679, 1'b0);
        expect_errs(e, f);
        frame_end(e, f);
        frm[4320 + 7] ^= 1'b1;
        feed(0, 4679, 1'b0);
        expect_errs(e, f);
        frame_end(e, f);
        after_pulse(e);
        check("b2b_two_done", done_cnt - d0, 2);
        if (stamps.size() >= 2) check("b2b_spacing", stamps[$] - stamps[$ - 1], 4680);
        else check("b2b_spacing", stamps.size(), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
